// File: rtl/muldiv_if.sv
// muldiv_if: issue/write-back handshake between the core and the RV32M multiply/divide unit.
interface muldiv_if;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr_in;
    logic        flush;
    logic        busy;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    modport master (output start, funct3, rs1_data, rs2_data, rd_addr_in, flush,
                    input busy, wb_valid, wb_rd, wb_data);
    modport slave (input start, funct3, rs1_data, rs2_data, rd_addr_in, flush,
                   output busy, wb_valid, wb_rd, wb_data);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide (shift-add multiply, restoring divide).
// Define MULDIV_FAST_MUL_EN for a single-cycle multiplier; the divide path is unchanged.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, next;
    logic [2:0] op;
    logic [4:0] rd;
    logic [XLEN-1:0] a, b, quo, rem;
    logic neg;
    logic [CNT_W-1:0] cnt;
    logic [2*XLEN-1:0] acc;
    logic [2:0] f;
    logic sa, sb, na, nb, div0, ovf, special, fast, accept;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0] mul_sum, div_sh;
    logic [XLEN+1:0] div_diff;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo_f, rem_f, res;
    always_comb begin
        f       = bus.funct3;
        sa      = (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
        sb      = (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
        na      = sa & bus.rs1_data[XLEN-1];
        nb      = sb & bus.rs2_data[XLEN-1];
        abs_a   = na ? -bus.rs1_data : bus.rs1_data;
        abs_b   = nb ? -bus.rs2_data : bus.rs2_data;
        div0    = f[2] && bus.rs2_data == '0;
        ovf     = f[2] && !f[0] && bus.rs1_data == 32'h8000_0000 && bus.rs2_data == 32'hFFFF_FFFF;
        special = div0 || ovf;
`ifdef MULDIV_FAST_MUL_EN
        fast    = !f[2];
`else
        fast    = 1'b0;
`endif
        accept  = state == IDLE && bus.start && !bus.flush;
    end
`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fa, fb, fp;
    always_comb begin
        fa = {{XLEN{na}}, bus.rs1_data};
        fb = {{XLEN{nb}}, bus.rs2_data};
        fp = fa * fb;
    end
`endif
    always_comb begin
        next = state;
        if (bus.flush) next = IDLE;
        else case (state)
            IDLE:    if (bus.start) next = (special || fast) ? FIX : CALC;
            CALC:    if (cnt == '1) next = FIX;
            FIX:     next = DONE;
            default: next = IDLE;
        endcase
    end
    // The remainder can never exceed the divisor, so only the shifted value needs the extra bit.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a} : '0);
        div_sh   = {rem, quo[XLEN-1]};
        div_diff = {1'b0, div_sh} - {2'b0, b};
        prod     = neg ? -acc : acc;
        quo_f    = neg ? -quo : quo;
        rem_f    = neg ? -rem : rem;
        res      = op[2] ? (op[1] ? rem_f : quo_f)
                         : (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
    assign bus.busy     = state != IDLE;
    assign bus.wb_valid = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op          <= '0;
            rd          <= '0;
            a           <= '0;
            b           <= '0;
            neg         <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            quo         <= '0;
            rem         <= '0;
            bus.wb_data <= '0;
            bus.wb_rd   <= '0;
        end else begin
            state <= next;
            if (accept) begin
                op  <= f;
                rd  <= bus.rd_addr_in;
                a   <= abs_a;
                b   <= abs_b;
                neg <= special ? 1'b0 : (f[2] & f[1]) ? na : na ^ nb;
                cnt <= '0;
                acc <= {{XLEN{1'b0}}, abs_b};
                quo <= div0 ? '1 : ovf ? 32'h8000_0000 : abs_a;
                rem <= div0 ? bus.rs1_data : '0;
`ifdef MULDIV_FAST_MUL_EN
                if (fast) begin
                    acc <= fp;
                    neg <= 1'b0;
                end
`endif
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                acc <= {mul_sum, acc[XLEN-1:1]};
                rem <= div_diff[XLEN+1] ? div_sh[XLEN-1:0] : div_diff[XLEN-1:0];
                quo <= {quo[XLEN-2:0], !div_diff[XLEN+1]};
            end else if (state == FIX && !bus.flush) begin
                bus.wb_data <= res;
                bus.wb_rd   <= rd;
            end
        end
    end
endmodule
